// File: rtl/demux15_stream.sv
// Streaming 1-to-5 demultiplexer with a small FIFO on every output lane.
// The lane select reuses the 3-bit code of the vector datapath's 5:1 operand muxes.
module demux15_stream #(
  parameter int ELEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_valid,
  output logic                               i_ready,
  input  logic [2:0]                         i_sel,
  input  logic [ELEN-1:0]                    i_data,
  output logic [4:0]                         o_valid,
  input  logic [4:0]                         o_ready,
  output logic [ELEN-1:0]                    o_data0,
  output logic [ELEN-1:0]                    o_data1,
  output logic [ELEN-1:0]                    o_data2,
  output logic [ELEN-1:0]                    o_data3,
  output logic [ELEN-1:0]                    o_data4,
  output logic [5*($clog2(DEPTH)+1)-1:0]     o_count
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int LANES = 5;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("demux15_stream: DEPTH must be a power of 2 and at least 2");
  end

  logic [2:0]       lane;
  logic [LANES-1:0] lane_onehot;
  logic [LANES-1:0] full;
  logic [LANES-1:0] empty;
  logic [LANES-1:0] push;
  logic [LANES-1:0] pop;
  logic [ELEN-1:0]  lane_data [LANES];

  // 01x and 10x/11x collapse onto one lane each, matching the operand mux code.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    lane = 3'd0;
    if (i_sel[2]) begin
      lane = i_sel[1] ? 3'd4 : 3'd3;
    end else if (i_sel[1]) begin
      lane = 3'd2;
    end else begin
      lane = {2'b00, i_sel[0]};
    end
  end

  always_comb begin
    lane_onehot = '0;
    case (lane)
      3'd0:    lane_onehot = 5'b00001;
      3'd1:    lane_onehot = 5'b00010;
      3'd2:    lane_onehot = 5'b00100;
      3'd3:    lane_onehot = 5'b01000;
      default: lane_onehot = 5'b10000;
    endcase
  end

  // Only registered fullness feeds i_ready: a lane popping this cycle still refuses input.
  assign i_ready = |(lane_onehot & ~full);
  assign push    = lane_onehot & {LANES{i_valid & i_ready}};
  assign pop     = o_valid & o_ready;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    logic [ELEN-1:0] mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [CW-1:0]   count;

    always_ff @(posedge clk) begin
      if (rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push[n]) wptr <= wptr + PW'(1);
        if (pop[n])  rptr <= rptr + PW'(1);
        case ({push[n], pop[n]})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end

    // NOTE: the storage array has no reset; validity is carried entirely by count.
    always_ff @(posedge clk) begin
      if (push[n]) mem[wptr] <= i_data;
    end

    assign full[n]              = (count == CW'(DEPTH));
    assign empty[n]             = (count == '0);
    assign o_valid[n]           = ~empty[n];
    assign lane_data[n]         = mem[rptr];
    assign o_count[n*CW +: CW]  = count;

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) push[n] |-> !full[n]);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) pop[n] |-> !empty[n]);
  end

  a_sel_known: assert property (@(posedge clk) disable iff (rst) i_valid |-> !$isunknown(i_sel));

  assign o_data0 = lane_data[0];
  assign o_data1 = lane_data[1];
  assign o_data2 = lane_data[2];
  assign o_data3 = lane_data[3];
  assign o_data4 = lane_data[4];

endmodule
